// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch, load/store and memory-side bundle of the arbiter
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W/8-1:0]   dm_be;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output busy
  );

  // Requesters plus memory side
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one fixed-latency memory between fetch and load/store
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_port_arbiter_if.slave bus
);
  localparam int c_cnt_w = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int c_stv_w = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_lat      = c_cnt_w'(MEM_LAT);
  localparam logic [c_stv_w-1:0] c_stv_max  = c_stv_w'(STARVE_MAX);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt,      w_cnt_nxt;
  logic [c_stv_w-1:0]   r_starve,   w_starve_nxt;
  logic                 r_owner_dm, w_owner_dm_nxt;
  logic                 r_store,    w_store_nxt;

  logic                 w_last;
  logic                 w_opp;
  logic                 w_gnt_if;
  logic                 w_gnt_dm;
  logic                 w_if_rvalid;
  logic                 w_dm_rvalid;
  logic [DATA_W-1:0]    w_if_rdata;
  logic [DATA_W-1:0]    w_dm_rdata;
  logic                 w_mem_we;
  logic [DATA_W/8-1:0]  w_mem_be;
  logic [ADDR_W-1:0]    w_mem_addr;
  logic [DATA_W-1:0]    w_mem_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_owner_dm <= 1'b0;
      r_store    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_starve   <= w_starve_nxt;
      r_owner_dm <= w_owner_dm_nxt;
      r_store    <= w_store_nxt;
    end
  end

  always_comb begin
    // The response cycle doubles as the next grant opportunity.
    w_last   = (r_state == S_WAIT) && (r_cnt == c_cnt_one);
    w_opp    = !rst && ((r_state == S_IDLE) || w_last);
    w_gnt_if = w_opp && bus.if_req && (!bus.dm_req || (r_starve == c_stv_max));
    w_gnt_dm = w_opp && bus.dm_req && !w_gnt_if;

    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_owner_dm_nxt = r_owner_dm;
    w_store_nxt    = r_store;
    w_starve_nxt   = r_starve;

    if (r_state == S_WAIT) begin
      w_cnt_nxt = r_cnt - c_cnt_one;
    end
    if (w_last) begin
      w_state_nxt = S_IDLE;
    end
    if (w_gnt_if || w_gnt_dm) begin
      w_state_nxt    = S_WAIT;
      w_cnt_nxt      = c_lat;
      w_owner_dm_nxt = w_gnt_dm;
      w_store_nxt    = w_gnt_dm && bus.dm_we;
    end

    if (!bus.if_req || w_gnt_if) begin
      w_starve_nxt = '0;
    end else if (w_opp && bus.dm_req && (r_starve != c_stv_max)) begin
      w_starve_nxt = r_starve + c_stv_w'(1);
    end

    w_mem_we    = 1'b0;
    w_mem_be    = '0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_gnt_if) begin
      w_mem_addr = bus.if_addr;
    end else if (w_gnt_dm) begin
      w_mem_we    = bus.dm_we;
      w_mem_be    = bus.dm_be;
      w_mem_addr  = bus.dm_addr;
      w_mem_wdata = bus.dm_wdata;
    end

    w_if_rvalid = w_last && !r_owner_dm;
    w_dm_rvalid = w_last && r_owner_dm;
    w_if_rdata  = w_if_rvalid ? bus.mem_rdata : '0;
    w_dm_rdata  = (w_dm_rvalid && !r_store) ? bus.mem_rdata : '0;
  end

  assign bus.if_gnt    = w_gnt_if;
  assign bus.dm_gnt    = w_gnt_dm;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = w_if_rdata;
  assign bus.dm_rdata  = w_dm_rdata;
  assign bus.mem_en    = w_gnt_if || w_gnt_dm;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_be    = w_mem_be;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.busy      = (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : vector table, corner sequences and random model check
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b1;
  int   sel = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        t_if_req, t_dm_req, t_dm_we;
  logic [31:0] t_if_addr, t_dm_addr, t_dm_wdata;
  logic [3:0]  t_dm_be;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  always #5 clk = ~clk;

  assign b1.if_req   = (sel == 0) && t_if_req;
  assign b1.if_addr  = (sel == 0) ? t_if_addr : '0;
  assign b1.dm_req   = (sel == 0) && t_dm_req;
  assign b1.dm_we    = (sel == 0) && t_dm_we;
  assign b1.dm_be    = (sel == 0) ? t_dm_be : '0;
  assign b1.dm_addr  = (sel == 0) ? t_dm_addr : '0;
  assign b1.dm_wdata = (sel == 0) ? t_dm_wdata : '0;
  assign b3.if_req   = (sel == 1) && t_if_req;
  assign b3.if_addr  = (sel == 1) ? t_if_addr : '0;
  assign b3.dm_req   = (sel == 1) && t_dm_req;
  assign b3.dm_we    = (sel == 1) && t_dm_we;
  assign b3.dm_be    = (sel == 1) ? t_dm_be : '0;
  assign b3.dm_addr  = (sel == 1) ? t_dm_addr : '0;
  assign b3.dm_wdata = (sel == 1) ? t_dm_wdata : '0;

  // Shared backing store with one read pipeline per latency
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] rd1;
  logic [31:0] rd3 [0:2];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? 32'h0000_0093 : 32'h1000_0000 + 32'(i);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (b1.mem_en && b1.mem_we && b1.mem_be[k]) mem[b1.mem_addr[9:2]][k*8 +: 8] <= b1.mem_wdata[k*8 +: 8];
        if (b3.mem_en && b3.mem_we && b3.mem_be[k]) mem[b3.mem_addr[9:2]][k*8 +: 8] <= b3.mem_wdata[k*8 +: 8];
      end
    end
    rd1    <= (b1.mem_en && !b1.mem_we) ? mem[b1.mem_addr[9:2]] : 32'hBAD0_BAD0;
    rd3[0] <= (b3.mem_en && !b3.mem_we) ? mem[b3.mem_addr[9:2]] : 32'hBAD0_BAD0;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = rd3[2];

  // View of whichever DUT is under test
  logic        o_ig, o_dg, o_irv, o_drv, o_men, o_mwe, o_busy;
  logic [31:0] o_ird, o_drd, o_maddr, o_mwd;
  logic [3:0]  o_mbe;
  assign o_ig    = (sel == 1) ? b3.if_gnt    : b1.if_gnt;
  assign o_dg    = (sel == 1) ? b3.dm_gnt    : b1.dm_gnt;
  assign o_irv   = (sel == 1) ? b3.if_rvalid : b1.if_rvalid;
  assign o_drv   = (sel == 1) ? b3.dm_rvalid : b1.dm_rvalid;
  assign o_ird   = (sel == 1) ? b3.if_rdata  : b1.if_rdata;
  assign o_drd   = (sel == 1) ? b3.dm_rdata  : b1.dm_rdata;
  assign o_men   = (sel == 1) ? b3.mem_en    : b1.mem_en;
  assign o_mwe   = (sel == 1) ? b3.mem_we    : b1.mem_we;
  assign o_mbe   = (sel == 1) ? b3.mem_be    : b1.mem_be;
  assign o_maddr = (sel == 1) ? b3.mem_addr  : b1.mem_addr;
  assign o_mwd   = (sel == 1) ? b3.mem_wdata : b1.mem_wdata;
  assign o_busy  = (sel == 1) ? b3.busy      : b1.busy;

  typedef struct {
    logic        ir, dr, dwe;
    logic [31:0] daddr, dwd;
    logic [3:0]  dbe;
    logic        eig, edg, ewe, eirv, edrv;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic ir, logic dr, logic dwe, logic [31:0] daddr, logic [31:0] dwd,
                              logic [3:0] dbe, logic eig, logic edg, logic ewe, logic eirv,
                              logic edrv, logic [31:0] erd);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.dbe = dbe;
    v.eig = eig; v.edg = edg; v.ewe = ewe; v.eirv = eirv; v.edrv = edrv; v.erd = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    t_if_req = 1'b0; t_if_addr = '0;
    t_dm_req = 1'b0; t_dm_we = 1'b0; t_dm_be = '0; t_dm_addr = '0; t_dm_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_random(input int s, input int ncyc);
    int          lat, due, starve;
    logic        own_dm, last_gi, last_gd, opp, gi, gd, e_irv, e_drv;
    logic [31:0] pend, e_ird, e_drd, e_maddr, e_mwd;
    logic [3:0]  e_mbe;
    sel = s;
    lat = (s == 1) ? 3 : 1;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    due = -1; starve = 0; own_dm = 1'b0; pend = '0; last_gi = 1'b0; last_gd = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (!t_if_req || last_gi) begin
        t_if_req  = ($urandom_range(0, 99) < 60);
        t_if_addr = 32'($urandom_range(0, 31)) * 4;
      end else if ($urandom_range(0, 99) < 5) begin
        t_if_req = 1'b0;
      end
      if (!t_dm_req || last_gd) begin
        t_dm_req   = ($urandom_range(0, 99) < 70);
        t_dm_we    = ($urandom_range(0, 1) == 1);
        t_dm_be    = 4'($urandom_range(1, 15));
        t_dm_addr  = 32'($urandom_range(0, 31)) * 4;
        t_dm_wdata = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        t_dm_req = 1'b0;
      end

      opp   = (due <= cyc);
      e_irv = (due == cyc) && !own_dm;
      e_drv = (due == cyc) && own_dm;
      e_ird = e_irv ? pend : 32'h0;
      e_drd = e_drv ? pend : 32'h0;
      gi    = opp && t_if_req && (!t_dm_req || starve == SMAX);
      gd    = opp && t_dm_req && !gi;
      e_maddr = gi ? t_if_addr : (gd ? t_dm_addr : 32'h0);
      e_mbe   = gd ? t_dm_be : 4'h0;
      e_mwd   = gd ? t_dm_wdata : 32'h0;

      @(negedge clk);
      check("rnd_gnt",       64'({o_ig, o_dg}), 64'({gi, gd}));
      check("rnd_rvalid",    64'({o_irv, o_drv}), 64'({e_irv, e_drv}));
      check("rnd_rdata",     {o_ird, o_drd}, {e_ird, e_drd});
      check("rnd_mem_ctl",   64'({o_men, o_mwe, o_mbe, o_maddr}), 64'({gi | gd, gd & t_dm_we, e_mbe, e_maddr}));
      check("rnd_mem_wdata", 64'(o_mwd), 64'(e_mwd));
      check("rnd_busy",      64'(o_busy), 64'(due >= cyc));

      if (gi || gd) begin
        due    = cyc + lat;
        own_dm = gd;
        pend   = (gd && t_dm_we) ? 32'h0 : ref_mem[e_maddr[9:2]];
        if (gd && t_dm_we)
          for (int k = 0; k < 4; k++)
            if (t_dm_be[k]) ref_mem[t_dm_addr[9:2]][k*8 +: 8] = t_dm_wdata[k*8 +: 8];
      end
      if (!t_if_req || gi) starve = 0;
      else if (opp && t_dm_req && starve < SMAX) starve = starve + 1;
      last_gi = gi;
      last_gd = gd;
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    tbl[0]  = mk(1, 0, 0, 32'h0,   32'h0,         4'h0, 1, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,   32'h0,         4'h0, 0, 0, 0, 1, 0, 32'h93);
    tbl[2]  = mk(0, 1, 1, 32'h100, 32'hDEADBEEF,  4'hF, 0, 1, 1, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 32'h100, 32'h0,         4'hF, 0, 1, 0, 0, 1, 32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,   32'h0,         4'h0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    tbl[5]  = mk(1, 1, 0, 32'h100, 32'h0,         4'hF, 0, 1, 0, 0, 0, 32'h0);
    tbl[6]  = mk(1, 1, 0, 32'h100, 32'h0,         4'hF, 0, 1, 0, 0, 1, 32'hDEADBEEF);
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = mk(1, 1, 0, 32'h100, 32'h0,         4'hF, 1, 0, 0, 0, 1, 32'hDEADBEEF);
    tbl[10] = mk(1, 1, 0, 32'h100, 32'h0,         4'hF, 0, 1, 0, 1, 0, 32'h93);
    tbl[11] = tbl[6];
    tbl[12] = tbl[6];
    tbl[13] = tbl[6];
    tbl[14] = tbl[9];
    tbl[15] = mk(0, 0, 0, 32'h0,   32'h0,         4'h0, 0, 0, 0, 1, 0, 32'h93);

    // Outputs stay quiet while reset is held, even with both requests up
    t_if_req = 1'b1; t_dm_req = 1'b1; t_dm_we = 1'b1; t_dm_be = 4'hF;
    tick();
    mem_load = 1'b0;
    tick();
    @(negedge clk);
    check("rst_gnt",    64'({o_ig, o_dg}), 64'h0);
    check("rst_mem",    64'({o_men, o_mwe, o_mbe, o_maddr}), 64'h0);
    check("rst_rvalid", 64'({o_irv, o_drv, o_busy}), 64'h0);
    check("rst_rdata",  {o_ird, o_drd}, 64'h0);
    tick();
    rst = 1'b0;
    drive_idle();

    // MEM_LAT=1 vector table: fetch, store/load round trip, starvation pattern
    for (int i = 0; i < 16; i++) begin
      t_if_req = tbl[i].ir; t_if_addr = 32'h0;
      t_dm_req = tbl[i].dr; t_dm_we = tbl[i].dwe; t_dm_addr = tbl[i].daddr;
      t_dm_wdata = tbl[i].dwd; t_dm_be = tbl[i].dbe;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i),    64'({o_ig, o_dg}), 64'({tbl[i].eig, tbl[i].edg}));
      check($sformatf("vec%0d_mem", i),    64'({o_men, o_mwe}), 64'({tbl[i].eig | tbl[i].edg, tbl[i].ewe}));
      check($sformatf("vec%0d_rvalid", i), 64'({o_irv, o_drv}), 64'({tbl[i].eirv, tbl[i].edrv}));
      check($sformatf("vec%0d_if_rd", i),  64'(o_ird), 64'(tbl[i].eirv ? tbl[i].erd : 32'h0));
      check($sformatf("vec%0d_dm_rd", i),  64'(o_drd), 64'(tbl[i].edrv ? tbl[i].erd : 32'h0));
      tick();
    end
    drive_idle();

    // MEM_LAT=3: data request raised during an outstanding fetch
    sel = 1;
    do_reset();
    t_if_req = 1'b1; t_if_addr = 32'h0;
    @(negedge clk);
    check("l3_t0_gnt",  64'({o_ig, o_dg, o_busy}), 64'b100);
    tick();
    t_if_req = 1'b0; t_dm_req = 1'b1; t_dm_we = 1'b0; t_dm_addr = 32'h100; t_dm_be = 4'hF;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      check($sformatf("l3_t%0d_gnt", t),  64'({o_ig, o_dg}), 64'({1'b0, t == 3}));
      check($sformatf("l3_t%0d_busy", t), 64'(o_busy), 64'(t <= 6));
      check($sformatf("l3_t%0d_rv", t),   64'({o_irv, o_drv}), 64'({t == 3, t == 6}));
      check($sformatf("l3_t%0d_rd", t),   {o_ird, o_drd},
            {(t == 3) ? 32'h93 : 32'h0, (t == 6) ? 32'hDEADBEEF : 32'h0});
      tick();
      if (t == 3) drive_idle();
    end

    // MEM_LAT=3: reset while a fetch is in flight discards its response
    t_if_req = 1'b1; t_if_addr = 32'h0;
    @(negedge clk);
    check("rstf_t0_gnt", 64'(o_ig), 64'h1);
    tick();
    rst = 1'b1; t_if_req = 1'b0;
    @(negedge clk);
    check("rstf_t1_quiet", 64'({o_ig, o_irv, o_busy, o_men}), 64'h0);
    tick();
    rst = 1'b0; t_if_req = 1'b1;
    @(negedge clk);
    check("rstf_t2_gnt", 64'(o_ig), 64'h1);
    tick();
    t_if_req = 1'b0;
    for (int t = 3; t <= 5; t++) begin
      @(negedge clk);
      check($sformatf("rstf_t%0d_rv", t), 64'({o_irv, o_ird}), 64'({t == 5, (t == 5) ? 32'h93 : 32'h0}));
      tick();
    end

    // MEM_LAT=3: byte store issues exactly one memory strobe
    t_dm_req = 1'b1; t_dm_we = 1'b1; t_dm_be = 4'h2; t_dm_addr = 32'h44; t_dm_wdata = 32'h0000_AB00;
    @(negedge clk);
    check("bstore_gnt", 64'({o_dg, o_men, o_mwe, o_mbe, o_maddr}), 64'({3'b111, 4'h2, 32'h44}));
    check("bstore_wd",  64'(o_mwd), 64'h0000_AB00);
    tick();
    drive_idle();
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      check($sformatf("bstore_t%0d_en", t), 64'(o_men), 64'h0);
      check($sformatf("bstore_t%0d_rv", t), 64'({o_drv, o_drd}), 64'({t == 3, 32'h0}));
      tick();
    end

    run_random(0, 300);
    run_random(1, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the core's single unified memory between the pipeline's instruction-fetch port and its load/store port. It sits between the fetch/memory-access stages of `Core` and the memory array, so instruction words and data live in one image loaded at address 0. The block grants one transaction at a time, tracks the fixed memory read latency, and routes the response back to the owner. A starvation counter bounds how long fetch can be locked out by back-to-back data accesses.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from memory issue to `mem_rdata` valid (≥1)
- `STARVE_MAX`, 4, consecutive lost arbitrations before fetch is forced
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; held with stable `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  fetch response pulse
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_rvalid`
- `dm_req`  in  1  data request; held with stable payload until `dm_gnt`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_be`  in  DATA_W/8  store byte enables
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_gnt`  out  1  data accepted this cycle
- `dm_rvalid`  out  1  data response pulse (load data or store ack)
- `dm_rdata`  out  DATA_W  load data with `dm_rvalid`; 0 for store acks
- `mem_en`, `mem_we`  out  1  memory issue strobe / write enable
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_addr`, `mem_wdata`  out  ADDR_W / DATA_W  memory address / write data
- `mem_rdata`  in  DATA_W  memory read data, MEM_LAT cycles after issue
- `busy`  out  1  a transaction is outstanding

## Operation
- At most one outstanding transaction; owner bit (IF/DM) and latency down-counter registered at grant.
- States: IDLE (nothing outstanding), WAIT (counter > 0). Grant opportunity exists in IDLE, or in WAIT when the counter hits its final cycle (response cycle).
- At a grant opportunity: if only one req, grant it. If both: grant DM, unless starvation count == STARVE_MAX, then grant IF.
- Starvation count: +1 (saturating at STARVE_MAX) each opportunity where `if_req` loses to DM; cleared on IF grant or when `if_req`=0.
- `gnt` is combinational in the grant cycle; `mem_en`=1 and `mem_*` driven from the winner's inputs in the same cycle; `mem_we`=0, `mem_be`=0 for fetches.
- Response: `<owner>_rvalid` pulses exactly one cycle, MEM_LAT cycles after grant; `<owner>_rdata` = `mem_rdata` (combinational pass-through) for reads, 0 for stores; non-owner rdata = 0.
- No request with `req`=0 is ever granted; `gnt` never asserted to both ports in one cycle.

## Timing
- Reset (async, immediate): state IDLE, counter 0, starvation 0, owner IF; all outputs 0 including `busy`; any in-flight response discarded (no `rvalid` after reset releases).
- Grant at cycle t → `rvalid` at t+MEM_LAT; next grant possible at t+MEM_LAT; throughput one access per MEM_LAT cycles.
- MEM_LAT=1: grant every cycle, `rvalid` the cycle after each grant.
- `busy`=1 from cycle after grant through response cycle inclusive.
- Requester dropping `req` before `gnt`: legal, nothing issued.
- Requests arriving mid-WAIT wait until the response cycle; arbitration uses values sampled in that cycle.

## Test plan
- Reset, MEM_LAT=1, `if_req`=1 only at addr 0x0 with memory word 0x00000093 → `if_gnt` same cycle, `if_rvalid`=1 and `if_rdata`=0x00000093 next cycle; all outputs 0 during reset.
- Both requests every cycle, MEM_LAT=1, STARVE_MAX=4 → grant pattern DM,DM,DM,DM,IF repeating; never both gnt.
- Store `dm_addr`=0x100, `dm_wdata`=0xDEADBEEF, `dm_be`=0xF, then load 0x100 → `mem_we`=1 on first grant, store ack `dm_rdata`=0, load returns 0xDEADBEEF.
- MEM_LAT=3, fetch at t=0 and data request raised t=1 → `dm_gnt` at t=3 with `if_rvalid` at t=3, `dm_rvalid` at t=6, `busy` high t=1..6.
- MEM_LAT=3, assert `rst` at t=1 after a fetch grant, release t=2 → no `if_rvalid` ever; fresh `if_req` granted at first cycle after release.
- Byte store `dm_be`=0x2 at 0x44 → `mem_be`=0x2, `mem_en`=1 for exactly one cycle.
